// File: rtl/floor_request_scheduler.sv
// Floor request scheduler: latches floor calls, tracks travel direction with a
// three-state SCAN machine and presents the next target floor as {valid, floor}.
module floor_request_scheduler #(
    parameter  int FLOORS = 4,
    localparam int FW     = $clog2(FLOORS)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [FLOORS-1:0] btn,
    input  logic [FW-1:0]     cur_floor,
    input  logic              arrived,
    output logic [FW:0]       n_stage,
    output logic              exit,
    output logic              dir_up,
    output logic              dir_dn,
    output logic [FLOORS-1:0] pending
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_UP   = 2'd1,
        S_DOWN = 2'd2
    } state_t;

    state_t            state_q, state_d;
    logic [FLOORS-1:0] pending_q, pending_d;
    logic [FW:0]       n_stage_q, n_stage_d;
    logic              exit_q, exit_d;
    logic              dir_up_q, dir_up_d;
    logic              dir_dn_q, dir_dn_d;

    logic              here, above, below;
    logic [FLOORS-1:0] clr;
    logic [FW-1:0]     up_tgt, dn_tgt;

    // Position flags, nearest targets in each direction and the arrival clear mask.
    // An out-of-range cur_floor never equals any index, so it clears nothing and
    // is never "here", while above/below still compare against the raw value.
    always_comb begin
        // NOTE: every signal written here gets a default first so no path leaves it
        // unassigned, which would otherwise infer a latch.
        here   = 1'b0;
        above  = 1'b0;
        below  = 1'b0;
        clr    = '0;
        up_tgt = '0;
        dn_tgt = '0;
        for (int i = 0; i < FLOORS; i++) begin
            clr[i] = arrived && (FW'(i) == cur_floor);
            if (pending_q[i]) begin
                if (FW'(i) == cur_floor) here  = 1'b1;
                if (FW'(i) >  cur_floor) above = 1'b1;
                if (FW'(i) <  cur_floor) below = 1'b1;
            end
        end
        // Descending scan: the last hit is the lowest pending floor above the car.
        for (int i = FLOORS - 1; i >= 0; i--) begin
            if (pending_q[i] && (FW'(i) > cur_floor)) up_tgt = FW'(i);
        end
        // Ascending scan: the last hit is the highest pending floor below the car.
        for (int i = 0; i < FLOORS; i++) begin
            if (pending_q[i] && (FW'(i) < cur_floor)) dn_tgt = FW'(i);
        end
    end

    // SCAN next state: keep going while work remains ahead, else reverse, else rest.
    always_comb begin
        state_d = S_IDLE;
        unique case (state_q)
            S_IDLE:  state_d = above ? S_UP   : (below ? S_DOWN : S_IDLE);
            S_UP:    state_d = above ? S_UP   : (below ? S_DOWN : S_IDLE);
            S_DOWN:  state_d = below ? S_DOWN : (above ? S_UP   : S_IDLE);
            default: state_d = S_IDLE;
        endcase
    end

    // Target selection from the next state; serving the current floor comes first.
    always_comb begin
        n_stage_d = '0;
        if (here) begin
            n_stage_d = {1'b1, cur_floor};
        end else if (state_d == S_UP) begin
            n_stage_d = {1'b1, up_tgt};
        end else if (state_d == S_DOWN) begin
            n_stage_d = {1'b1, dn_tgt};
        end
        exit_d    = n_stage_d[FW] && (n_stage_d[FW-1:0] == cur_floor);
        dir_up_d  = (state_d == S_UP);
        dir_dn_d  = (state_d == S_DOWN);
        // Clear beats a same-cycle press: the floor is being served right now.
        pending_d = (pending_q | btn) & ~clr;
    end

    // State, request and output registers.
    always_ff @(posedge clk or posedge rst) begin
        // NOTE: sequential state uses non-blocking assignments so every register
        // samples the pre-edge values regardless of statement order.
        if (rst) begin
            state_q   <= S_IDLE;
            pending_q <= '0;
            n_stage_q <= '0;
            exit_q    <= 1'b0;
            dir_up_q  <= 1'b0;
            dir_dn_q  <= 1'b0;
        end else begin
            state_q   <= state_d;
            pending_q <= pending_d;
            n_stage_q <= n_stage_d;
            exit_q    <= exit_d;
            dir_up_q  <= dir_up_d;
            dir_dn_q  <= dir_dn_d;
        end
    end

    assign n_stage = n_stage_q;
    assign exit    = exit_q;
    assign dir_up  = dir_up_q;
    assign dir_dn  = dir_dn_q;
    assign pending = pending_q;

endmodule

// File: tb/tb_floor_request_scheduler.sv
// Bench for floor_request_scheduler: four instances (2, 4, 6 and 8 floors) run
// side by side against a behavioural model; directed scenarios on the 4-floor one.
module tb_floor_request_scheduler;

    localparam int N = 4;

    function automatic int fl_of(int g);
        case (g)
            0:       return 2;
            1:       return 4;
            2:       return 6;
            default: return 8;
        endcase
    endfunction

    logic clk = 1'b0;
    logic rst = 1'b1;

    logic [15:0] btn_v [N];
    logic [3:0]  cur_v [N];
    logic        arr_v [N];

    logic [N-1:0][4:0]  ns_o;
    logic [N-1:0][15:0] pd_o;
    logic [N-1:0]       ex_o, up_o, dn_o;

    always #5 clk = ~clk;

    for (genvar g = 0; g < N; g++) begin : g_dut
        localparam int F = fl_of(g);
        localparam int W = $clog2(F);
        logic [W:0]   ns;
        logic [F-1:0] pd;
        logic         ex, up, dn;

        floor_request_scheduler #(.FLOORS(F)) u_dut (
            .clk       (clk),
            .rst       (rst),
            .btn       (btn_v[g][F-1:0]),
            .cur_floor (cur_v[g][W-1:0]),
            .arrived   (arr_v[g]),
            .n_stage   (ns),
            .exit      (ex),
            .dir_up    (up),
            .dir_dn    (dn),
            .pending   (pd)
        );

        assign ns_o[g] = 5'(ns);
        assign pd_o[g] = 16'(pd);
        assign ex_o[g] = ex;
        assign up_o[g] = up;
        assign dn_o[g] = dn;
    end

    // ---------------- reference model ----------------
    // Direction: 0 idle, 1 up, 2 down.
    typedef struct {
        int pend;
        int dir;
        int ns;
        bit ex;
        bit up;
        bit dn;
    } mdl_t;

    mdl_t mdl [N];

    function automatic mdl_t mdl_reset();
        mdl_t r;
        r.pend = 0; r.dir = 0; r.ns = 0; r.ex = 0; r.up = 0; r.dn = 0;
        return r;
    endfunction

    // One clock edge of the scheduler, from the written rules.
    function automatic mdl_t step(mdl_t m, int f, int btn, int cur, bit arr);
        mdl_t r;
        bit   here = 0, above = 0, below = 0, vld = 0, found = 0;
        int   nd, tgt = 0, clr = 0;
        for (int i = 0; i < f; i++) begin
            if (((m.pend >> i) & 1) == 1) begin
                if (i == cur) here = 1;
                if (i > cur)  above = 1;
                if (i < cur)  below = 1;
            end
        end
        if (m.dir == 2) nd = below ? 2 : (above ? 1 : 0);
        else            nd = above ? 1 : (below ? 2 : 0);
        if (here) begin
            vld = 1; tgt = cur;
        end else if (nd == 1) begin
            for (int i = cur + 1; i < f; i++)
                if (!found && ((m.pend >> i) & 1) == 1) begin found = 1; tgt = i; end
            vld = 1;
        end else if (nd == 2) begin
            for (int i = cur - 1; i >= 0; i--)
                if (!found && ((m.pend >> i) & 1) == 1) begin found = 1; tgt = i; end
            vld = 1;
        end
        r.dir  = nd;
        r.ns   = vld ? ((1 << $clog2(f)) | tgt) : 0;
        r.ex   = vld && (tgt == cur);
        r.up   = (nd == 1);
        r.dn   = (nd == 2);
        if (arr && cur < f) clr = 1 << cur;
        r.pend = (m.pend | btn) & ~clr & ((1 << f) - 1);
        return r;
    endfunction

    // ---------------- checking ----------------
    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string tag, input int got, input int exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic check_all();
        for (int g = 0; g < N; g++) begin
            check($sformatf("pending[%0d]", g), int'(pd_o[g]), mdl[g].pend);
            check($sformatf("n_stage[%0d]", g), int'(ns_o[g]), mdl[g].ns);
            check($sformatf("exit[%0d]", g),    int'(ex_o[g]), int'(mdl[g].ex));
            check($sformatf("dir_up[%0d]", g),  int'(up_o[g]), int'(mdl[g].up));
            check($sformatf("dir_dn[%0d]", g),  int'(dn_o[g]), int'(mdl[g].dn));
        end
    endtask

    // Advance one edge with the inputs currently driven; compare all instances.
    task automatic tick();
        for (int g = 0; g < N; g++)
            mdl[g] = step(mdl[g], fl_of(g), int'(btn_v[g]), int'(cur_v[g]), arr_v[g]);
        @(posedge clk);
        #1;
        check_all();
    endtask

    task automatic idle_inputs();
        for (int g = 0; g < N; g++) begin
            btn_v[g] = '0; cur_v[g] = '0; arr_v[g] = 1'b0;
        end
    endtask

    task automatic set4(input int btn, input int cur, input bit arr);
        btn_v[1] = 16'(btn); cur_v[1] = 4'(cur); arr_v[1] = arr;
    endtask

    // Asynchronous reset asserted away from any edge; outputs must drop at once.
    task automatic do_reset();
        rst = 1'b1;
        #1;
        for (int g = 0; g < N; g++) mdl[g] = mdl_reset();
        check_all();
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
    endtask

    initial begin
        idle_inputs();
        for (int g = 0; g < N; g++) mdl[g] = mdl_reset();
        #1;
        check_all();
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;

        // Single call from floor 0 to floor 2.
        set4(4'b0100, 0, 0); tick();
        check("call_pending", int'(pd_o[1]), 4);
        set4(0, 0, 0); tick();
        check("call_ns", int'(ns_o[1]), 3'b110);
        check("call_up", int'(up_o[1]), 1);
        check("call_exit", int'(ex_o[1]), 0);
        set4(0, 2, 0); tick();
        check("call_exit_at2", int'(ex_o[1]), 1);
        set4(0, 2, 1); tick();
        check("call_cleared", int'(pd_o[1]), 0);
        set4(0, 2, 0); tick();
        check("call_ns_none", int'(ns_o[1]), 0);
        check("call_idle", int'(up_o[1] | dn_o[1]), 0);

        // SCAN order: moving up from 1 with calls at 0 and 3.
        set4(4'b1000, 0, 0); tick();
        set4(0, 0, 0);       tick();
        set4(4'b0001, 1, 0); tick();
        set4(0, 1, 0);       tick();
        check("scan_ns_up", int'(ns_o[1]), 3'b111);
        check("scan_dir_up", int'(up_o[1]), 1);
        set4(0, 3, 0); tick();
        set4(0, 3, 1); tick();
        set4(0, 3, 0); tick();
        check("scan_ns_down", int'(ns_o[1]), 3'b100);
        check("scan_dir_dn", int'(dn_o[1]), 1);
        set4(0, 0, 1); tick();
        set4(0, 0, 0); tick();

        // Here-first while moving up.
        set4(4'b1000, 0, 0); tick();
        set4(0, 0, 0);       tick();
        set4(4'b0010, 1, 0); tick();
        set4(0, 1, 0);       tick();
        check("here_ns", int'(ns_o[1]), 3'b101);
        check("here_exit", int'(ex_o[1]), 1);
        set4(0, 1, 1); tick();
        set4(0, 1, 0); tick();
        check("here_next", int'(ns_o[1]), 3'b111);

        // Mid-run reset with pending = 1010.
        set4(4'b0010, 1, 0); tick();
        check("rst_pre_pending", int'(pd_o[1]), 4'b1010);
        set4(0, 1, 0);
        do_reset();
        check("rst_pending", int'(pd_o[1]), 0);
        tick();
        check("rst_after_ns", int'(ns_o[1]), 0);

        // Clear-wins collision at floor 2, then a held button re-sets it.
        set4(4'b0100, 2, 1); tick();
        check("coll_cleared", int'(pd_o[1]), 0);
        set4(4'b0100, 2, 0); tick();
        check("coll_reset", int'(pd_o[1]), 4'b0100);
        set4(0, 2, 1); tick();
        set4(0, 2, 0); tick();

        // Parameter sweep: top floor from floor 0, out-of-range arrival ignored.
        btn_v[0] = 16'h0002; btn_v[3] = 16'h0080; btn_v[2] = 16'h0020;
        tick();
        btn_v[0] = '0; btn_v[3] = '0; btn_v[2] = '0;
        tick();
        check("sweep2_ns", int'(ns_o[0]), 2'b11);
        check("sweep8_ns", int'(ns_o[3]), 4'b1111);
        cur_v[2] = 4'd6; arr_v[2] = 1'b1; tick();
        check("oor_pending", int'(pd_o[2]), 16'h0020);
        cur_v[2] = 4'd7; tick();
        check("oor_pending2", int'(pd_o[2]), 16'h0020);
        idle_inputs();

        // Randomized traffic on all instances.
        for (int c = 0; c < 1500; c++) begin
            for (int g = 0; g < N; g++) begin
                int f = fl_of(g);
                int b = 0;
                for (int i = 0; i < f; i++)
                    if ($urandom_range(0, 9) == 0) b |= (1 << i);
                btn_v[g] = 16'(b);
                if ($urandom_range(0, 3) == 0)
                    cur_v[g] = 4'($urandom_range(0, (1 << $clog2(f)) - 1));
                arr_v[g] = ($urandom_range(0, 2) == 0);
            end
            if ($urandom_range(0, 299) == 0) do_reset();
            else tick();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
